mem_responder: RTL and testbench
================================

Name: mem_responder

Overview:
- Memory-side responder for the datapath's MAR/MDR bus. It services the Read and Write strobes that the control sequence raises during instruction fetch (T0–T2), ld (T5–T7) and st.
- It replaces the hand-driven Mdatain stimulus with a word-addressed RAM. The RAM has a configurable wait-state count and a one-cycle ready handshake, so the control unit can stall on memory.
- It sits between the MAR output, the MDR output and the MDR's Mdatain input.

Parameters:
- ADDR_WIDTH, 9, number of low MAR bits used as the word address (depth = 2**ADDR_WIDTH words).
- DATA_WIDTH, 32, word width. Must match the MDR.
- WAIT_STATES, 2, idle cycles inserted between request acceptance and the access. Legal range 0–15.
- INIT_FILE, "", hex file loaded at elaboration. If empty, memory is not initialised.

Ports:
- Clock  in  1  system clock; all state changes on its rising edge.
- clear  in  1  asynchronous, active-low reset (clear=0 resets).
- MAR_addr  in  32  address from MAR. Only bits [ADDR_WIDTH-1:0] are used.
- Read  in  1  read request strobe (level).
- Write  in  1  write request strobe (level).
- MDR_out  in  DATA_WIDTH  store data from MDR.
- Mdatain  out  DATA_WIDTH  read data to the MDR input mux.
- Mem_ready  out  1  one-cycle pulse: the access has completed.
- Mem_busy  out  1  high from acceptance until the request is released.
- Mem_err  out  1  one-cycle pulse: illegal request (Read and Write both high).

Behaviour:
- Reset (clear=0, asynchronous):
  - State goes to IDLE.
  - Mdatain=0, Mem_ready=0, Mem_busy=0, Mem_err=0, wait counter=0.
  - RAM contents are NOT cleared.
- FSM states: IDLE, WAIT, ACCESS, RESP, HOLD.
- IDLE:
  - Read^Write=1: latch addr = MAR_addr[ADDR_WIDTH-1:0], wdata = MDR_out and the op. Set Mem_busy=1. Load counter = WAIT_STATES. Go to WAIT, or directly to ACCESS if WAIT_STATES=0.
  - Read&Write=1: pulse Mem_err for one cycle and go to HOLD. No access occurs.
  - Neither strobe high: stay in IDLE.
- WAIT: decrement the counter each cycle. Go to ACCESS in the cycle the counter reaches 1.
- ACCESS:
  - Read: Mdatain <= mem[addr].
  - Write: mem[addr] <= wdata. Mdatain is unchanged.
  - Go to RESP.
- RESP: Mem_ready=1 for exactly this cycle, then go to HOLD.
- HOLD: stay while Read or Write is high. Go to IDLE (Mem_busy=0) in the cycle after both strobes are low.
  - A strobe held high across several cycles therefore produces exactly one access.
- Latency: with the request accepted at edge N, Mem_ready is high in the cycle after edge N+WAIT_STATES+1. Read data is valid on Mdatain at the same time as Mem_ready.
- Mdatain holds the last read value until the next completed read. Writes and errors do not disturb it.
- Address aliasing: upper MAR bits are ignored. With ADDR_WIDTH=9, address 0x200 maps to word 0x000.
- Address, data and op are latched at acceptance. Changes to MAR_addr, MDR_out or the strobes after acceptance have no effect on the in-flight access.
- Reset mid-operation:
  - An asserted reset before the ACCESS edge aborts the access; no RAM write commits.
  - A reset after the ACCESS edge leaves the committed write in place.
  - Mdatain is forced to 0.
- Simultaneous reset release and request: the request is evaluated on the first edge with clear=1.
- Read of a location never written or initialised returns X in simulation. The bench must initialise the location first.

Test Plan:
- WAIT_STATES=2: Write=1, MAR_addr=0x07, MDR_out=0x08800007, held 2 cycles, then released. Required: Mem_ready pulses once, 4 cycles after acceptance; mem[7]=0x08800007; Mdatain stays 0.
- Read=1 at MAR_addr=0x07 after the write above. Required: Mdatain=0x08800007 in the Mem_ready cycle; value holds after Read drops; a subsequent write to 0x08 leaves Mdatain unchanged.
- Read and Write both high at MAR_addr=0x10. Required: Mem_err pulses one cycle, no Mem_ready, mem[0x10] unchanged, Mem_busy stays high until both strobes drop.
- Read held high for 10 cycles at MAR_addr=0x07. Required: exactly one Mem_ready pulse; Mem_busy falls 1 cycle after Read drops.
- Write 0xDEADBEEF to MAR_addr=0x00000200, then read MAR_addr=0x00000000 (ADDR_WIDTH=9). Required: Mdatain=0xDEADBEEF (alias).
- Write 0x12345678 to 0x20 with mem[0x20]=0xAAAAAAAA preloaded; pulse clear=0 during WAIT. Required: Mdatain=0, Mem_busy=0, no Mem_ready; a subsequent read of 0x20 returns 0xAAAAAAAA. Repeat with WAIT_STATES=0: Mem_ready comes 2 cycles after acceptance.

Source files
------------

// File: rtl/mem_responder_if.sv
// MAR/MDR memory bus shared by the control unit/datapath (master) and the memory responder (slave).
// Handshake: Read/Write are level requests, held until Mem_ready (or Mem_err) is seen and then released;
// Mem_ready/Mem_err are one-cycle pulses and Mem_busy spans acceptance to the cycle after release.
interface mem_responder_if #(
   parameter int DATA_WIDTH = 32
);
   logic [31:0]           MAR_addr;
   logic                  Read;
   logic                  Write;
   logic [DATA_WIDTH-1:0] MDR_out;
   logic [DATA_WIDTH-1:0] Mdatain;
   logic                  Mem_ready;
   logic                  Mem_busy;
   logic                  Mem_err;

   modport master (
      output MAR_addr, Read, Write, MDR_out,
      input  Mdatain, Mem_ready, Mem_busy, Mem_err
   );

   modport slave (
      input  MAR_addr, Read, Write, MDR_out,
      output Mdatain, Mem_ready, Mem_busy, Mem_err
   );
endinterface

// File: rtl/mem_responder.sv
// Word-addressed RAM responder for the MAR/MDR bus with programmable wait states.
// One access per request: address/data/op are captured at acceptance, the strobe must drop before the next request.
module mem_responder #(
   parameter int    ADDR_WIDTH  = 9,
   parameter int    DATA_WIDTH  = 32,
   parameter int    WAIT_STATES = 2,
   parameter string INIT_FILE   = ""
) (
   input  logic            Clock,
   input  logic            clear,
   mem_responder_if.slave  bus,
   output logic [2:0]      state_dbg
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WAIT   = 3'd1,
      S_ACCESS = 3'd2,
      S_RESP   = 3'd3,
      S_HOLD   = 3'd4
   } state_t;

   localparam int          DEPTH     = 2 ** ADDR_WIDTH;
   localparam logic [3:0]  WAIT_INIT = 4'(WAIT_STATES);

   state_t                state;
   state_t                state_nxt;
   logic [3:0]            wait_cnt;
   logic [3:0]            wait_cnt_nxt;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  op_wr_q;
   logic                  err_q;
   logic                  req_one;
   logic                  req_both;
   logic                  req_any;
   logic                  accept;
   logic                  unused_addr_hi;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   assign req_one        = bus.Read ^ bus.Write;
   assign req_both       = bus.Read & bus.Write;
   assign req_any        = bus.Read | bus.Write;
   assign accept         = (state == S_IDLE) && req_one;
   assign unused_addr_hi = ^bus.MAR_addr[31:ADDR_WIDTH];

   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_IDLE: begin
            if (req_both) begin
               state_nxt = S_HOLD;
            end else if (req_one) begin
               wait_cnt_nxt = WAIT_INIT;
               state_nxt    = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;
            end
         end
         // Leave on the edge where the count is 1, so WAIT lasts exactly WAIT_STATES cycles.
         S_WAIT: begin
            if (wait_cnt != 4'd0) begin
               wait_cnt_nxt = wait_cnt - 4'd1;
            end
            if (wait_cnt <= 4'd1) begin
               state_nxt = S_ACCESS;
            end
         end
         S_ACCESS: state_nxt = S_RESP;
         S_RESP:   state_nxt = S_HOLD;
         S_HOLD: begin
            if (!req_any) begin
               state_nxt = S_IDLE;
            end
         end
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge Clock or negedge clear) begin
      if (!clear) begin
         state    <= S_IDLE;
         wait_cnt <= 4'd0;
         addr_q   <= '0;
         wdata_q  <= '0;
         op_wr_q  <= 1'b0;
         err_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
         err_q    <= (state == S_IDLE) && req_both;
         if (accept) begin
            addr_q  <= bus.MAR_addr[ADDR_WIDTH-1:0];
            wdata_q <= bus.MDR_out;
            op_wr_q <= bus.Write;
         end
         if ((state == S_ACCESS) && !op_wr_q) begin
            rdata_q <= mem[addr_q];
         end
      end
   end

   // No reset on the array: contents survive clear, and an async reset before this edge leaves state != ACCESS.
   always_ff @(posedge Clock) begin
      if ((state == S_ACCESS) && op_wr_q) begin
         mem[addr_q] <= wdata_q;
      end
   end

   assign bus.Mdatain   = rdata_q;
   assign bus.Mem_ready = (state == S_RESP);
   assign bus.Mem_busy  = (state != S_IDLE);
   assign bus.Mem_err   = err_q;
   assign state_dbg     = state;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: two instances (2 and 0 wait states) share one stimulus stream and a
// behavioural memory model; each request is checked for latency, pulse counts, busy span and read data.
module tb_mem_responder;

   localparam int AW   = 9;
   localparam int DW   = 32;
   localparam int WS_A = 2;
   localparam int WS_B = 0;

   logic          Clock = 1'b0;
   logic          clear = 1'b0;
   logic [31:0]   mar_addr = '0;
   logic          rd = 1'b0;
   logic          wr = 1'b0;
   logic [31:0]   mdr_out = '0;
   logic [2:0]    state_a;
   logic [2:0]    state_b;

   mem_responder_if #(.DATA_WIDTH(DW)) bus_a ();
   mem_responder_if #(.DATA_WIDTH(DW)) bus_b ();

   assign bus_a.MAR_addr = mar_addr;
   assign bus_a.Read     = rd;
   assign bus_a.Write    = wr;
   assign bus_a.MDR_out  = mdr_out;
   assign bus_b.MAR_addr = mar_addr;
   assign bus_b.Read     = rd;
   assign bus_b.Write    = wr;
   assign bus_b.MDR_out  = mdr_out;

   mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS_A), .INIT_FILE("")) dut_a (
      .Clock(Clock), .clear(clear), .bus(bus_a), .state_dbg(state_a));
   mem_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .WAIT_STATES(WS_B), .INIT_FILE("")) dut_b (
      .Clock(Clock), .clear(clear), .bus(bus_b), .state_dbg(state_b));

   always #5 Clock = ~Clock;

   logic        rdy_s  [2];
   logic        busy_s [2];
   logic        err_s  [2];
   logic [31:0] dat_s  [2];
   assign rdy_s[0]  = bus_a.Mem_ready;
   assign rdy_s[1]  = bus_b.Mem_ready;
   assign busy_s[0] = bus_a.Mem_busy;
   assign busy_s[1] = bus_b.Mem_busy;
   assign err_s[0]  = bus_a.Mem_err;
   assign err_s[1]  = bus_b.Mem_err;
   assign dat_s[0]  = bus_a.Mdatain;
   assign dat_s[1]  = bus_b.Mdatain;

   int          checks = 0;
   int          errors = 0;
   int          ws [2] = '{WS_A, WS_B};
   logic [31:0] mem_model [int];
   int          keys_q [$];
   logic [31:0] last_rd = '0;

   // One request from an idle bus: strobes high for 'hold' edges (edge 1 = acceptance), then released.
   task automatic run_txn(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] dat, input int hold, input string name);
      int          n_rdy [2];
      int          at_rdy [2];
      int          n_err [2];
      int          last_busy [2];
      int          bad_dat [2];
      int          key;
      int          exp_busy;
      logic        valid;
      logic [31:0] exp_new;
      logic [31:0] old_rd;
      logic [31:0] exp_dat;
      key     = int'(a[AW-1:0]);
      valid   = r ^ w;
      old_rd  = last_rd;
      exp_new = (valid && r) ? mem_model[key] : last_rd;
      for (int d = 0; d < 2; d++) begin
         n_rdy[d] = 0; at_rdy[d] = 0; n_err[d] = 0; last_busy[d] = 0; bad_dat[d] = 0;
      end
      rd = r; wr = w; mar_addr = a; mdr_out = dat;
      for (int k = 1; k <= hold + 7; k++) begin
         @(posedge Clock); #1;
         if (k == 1) begin
            mar_addr = $urandom;
            mdr_out  = $urandom;
         end
         if (k == hold) begin
            rd = 1'b0; wr = 1'b0;
         end
         @(negedge Clock);
         for (int d = 0; d < 2; d++) begin
            if (rdy_s[d] === 1'b1) begin
               n_rdy[d]++;
               if (n_rdy[d] == 1) at_rdy[d] = k;
            end
            if (err_s[d] === 1'b1) n_err[d]++;
            if (busy_s[d] === 1'b1) last_busy[d] = k;
            exp_dat = (valid && r && k >= ws[d] + 2) ? exp_new : old_rd;
            if (dat_s[d] !== exp_dat) bad_dat[d]++;
         end
      end
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (n_rdy[d] != (valid ? 1 : 0)) begin
            errors++;
            $display("FAIL %s dut%0d ready_pulses got %0d want %0d", name, d, n_rdy[d], valid ? 1 : 0);
         end
         if (valid) begin
            checks++;
            if (at_rdy[d] != ws[d] + 2) begin
               errors++;
               $display("FAIL %s dut%0d ready_cycle got %0d want %0d", name, d, at_rdy[d], ws[d] + 2);
            end
         end
         checks++;
         if (n_err[d] != (valid ? 0 : 1)) begin
            errors++;
            $display("FAIL %s dut%0d err_pulses got %0d want %0d", name, d, n_err[d], valid ? 0 : 1);
         end
         exp_busy = valid ? ((hold > ws[d] + 3) ? hold : ws[d] + 3) : ((hold > 1) ? hold : 1);
         checks++;
         if (last_busy[d] != exp_busy) begin
            errors++;
            $display("FAIL %s dut%0d busy_last_cycle got %0d want %0d", name, d, last_busy[d], exp_busy);
         end
         checks++;
         if (bad_dat[d] != 0 || dat_s[d] !== exp_new) begin
            errors++;
            $display("FAIL %s dut%0d mdatain got %h want %h (bad cycles %0d)", name, d, dat_s[d], exp_new, bad_dat[d]);
         end
      end
      if (valid && w) begin
         if (!mem_model.exists(key)) keys_q.push_back(key);
         mem_model[key] = dat;
      end
      if (valid && r) last_rd = exp_new;
   endtask

   task automatic test_reset();
      @(negedge Clock);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dat_s[d] !== 32'h0 || rdy_s[d] !== 1'b0 || busy_s[d] !== 1'b0 || err_s[d] !== 1'b0) begin
            errors++;
            $display("FAIL reset dut%0d outputs got dat=%h rdy=%b busy=%b err=%b want 0/0/0/0",
                     d, dat_s[d], rdy_s[d], busy_s[d], err_s[d]);
         end
      end
      @(posedge Clock); #1;
      clear = 1'b1;
      @(negedge Clock);
   endtask

   task automatic test_write_read();
      run_txn(1'b0, 1'b1, 32'h07, 32'h08800007, 2, "write07");
      run_txn(1'b1, 1'b0, 32'h07, 32'h0, 2, "read07");
      run_txn(1'b0, 1'b1, 32'h08, 32'h0BADF00D, 1, "write08_keeps_mdatain");
   endtask

   task automatic test_error();
      run_txn(1'b0, 1'b1, 32'h10, 32'h10101010, 1, "init10");
      run_txn(1'b1, 1'b1, 32'h10, 32'hFFFFFFFF, 3, "both_strobes10");
      run_txn(1'b1, 1'b0, 32'h10, 32'h0, 1, "read10_after_err");
   endtask

   task automatic test_held_read();
      run_txn(1'b1, 1'b0, 32'h07, 32'h0, 10, "read07_held10");
   endtask

   task automatic test_alias();
      run_txn(1'b0, 1'b1, 32'h00000200, 32'hDEADBEEF, 1, "write200");
      run_txn(1'b1, 1'b0, 32'h00000000, 32'h0, 1, "read000_alias");
   endtask

   // Reset pulse after acceptance edge 'at_edge'; before the commit edge the write must vanish.
   task automatic reset_during_write(input logic [31:0] a, input logic [31:0] dat, input int at_edge,
                                     input string name);
      int seen;
      rd = 1'b0; wr = 1'b1; mar_addr = a; mdr_out = dat;
      for (int k = 1; k <= at_edge; k++) @(posedge Clock);
      #1;
      clear = 1'b0;
      wr    = 1'b0;
      #2;
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dat_s[d] !== 32'h0 || busy_s[d] !== 1'b0 || rdy_s[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s dut%0d in_reset got dat=%h busy=%b rdy=%b want 0/0/0", name, d, dat_s[d], busy_s[d], rdy_s[d]);
         end
      end
      clear = 1'b1;
      seen  = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge Clock);
         for (int d = 0; d < 2; d++) if (rdy_s[d] !== 1'b0 || busy_s[d] !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
         errors++;
         $display("FAIL %s post_reset_activity got %0d want 0", name, seen);
      end
      last_rd = 32'h0;
   endtask

   task automatic test_reset_abort();
      run_txn(1'b0, 1'b1, 32'h20, 32'hAAAAAAAA, 1, "preload20");
      reset_during_write(32'h20, 32'h12345678, 1, "reset_in_wait");
      run_txn(1'b1, 1'b0, 32'h20, 32'h0, 2, "read20_after_abort");
   endtask

   task automatic test_reset_after_commit();
      run_txn(1'b0, 1'b1, 32'h30, 32'h11111111, 1, "preload30");
      reset_during_write(32'h30, 32'h55555555, WS_A + 2, "reset_after_commit");
      mem_model[32'h30] = 32'h55555555;
      run_txn(1'b1, 1'b0, 32'h30, 32'h0, 1, "read30_after_commit");
   endtask

   task automatic test_random();
      int          op;
      int          key;
      logic [31:0] a;
      for (int i = 0; i < 24; i++) begin
         op = $urandom_range(0, 3);
         if (op == 2 && keys_q.size() > 0) begin
            key = keys_q[$urandom_range(0, keys_q.size() - 1)];
            a   = ($urandom & 32'hFFFFFE00) | 32'(key);
            run_txn(1'b1, 1'b0, a, $urandom, $urandom_range(1, 5), "rand_read");
         end else if (op == 3) begin
            run_txn(1'b1, 1'b1, $urandom, $urandom, $urandom_range(1, 5), "rand_err");
         end else begin
            run_txn(1'b0, 1'b1, $urandom, $urandom, $urandom_range(1, 5), "rand_write");
         end
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_error();
      test_held_read();
      test_alias();
      test_reset_abort();
      test_reset_after_commit();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
